pd24_decoder_pipe: RTL and testbench

- Registered 2-to-4 one-hot decoder with a valid/ready handshake and a 2-entry skid buffer.
- Consumes the {any, code[1:0]} stream produced by the team's 4-to-2 priority encoder (PE42_D) and restores the one-hot line vector Y3..Y0.
- Sits on the receive side of the encoded line-select path, so encoded selects can cross registered, back-pressured links.

---
 rtl/pd_pkg.sv | 20 ++
 rtl/pd24_decoder_pipe_if.sv | 27 ++
 rtl/pd_skid_buf.sv | 50 +++++
 rtl/pd24_decoder_pipe.sv | 62 ++++++
 tb/tb_pd24_decoder_pipe.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/pd_pkg.sv
// Shared definitions for the pd24 decode path: widths, one-hot decode, occupancy states.
package pd_pkg;

  localparam int unsigned PD_CODE_W = 2;
  localparam int unsigned PD_OUT_W  = 1 << PD_CODE_W;
  localparam int unsigned PD_CNT_W  = 8;

  typedef enum logic [1:0] {
    PD_EMPTY = 2'd0,
    PD_ONE   = 2'd1,
    PD_FULL  = 2'd2
  } pd_state_e;

  // One-hot restore of an encoder word; a word with any=0 decodes to all-zero.
  function automatic logic [PD_OUT_W-1:0] pd_decode(input logic [PD_CODE_W-1:0] code,
                                                    input logic                 any);
    return any ? (PD_OUT_W'(1) << code) : '0;
  endfunction

endpackage

// File: rtl/pd24_decoder_pipe_if.sv
// Valid/ready bus around the decoder: encoded words in, one-hot vectors out.
interface pd24_decoder_pipe_if
  import pd_pkg::*;
#(
  parameter int unsigned CODE_W = PD_CODE_W
);
  localparam int unsigned OUT_W = 1 << CODE_W;

  logic              in_valid;
  logic              in_ready;
  logic [CODE_W-1:0] in_code;
  logic              in_any;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_y;

  modport slave (
    input  in_valid, in_code, in_any, out_ready,
    output in_ready, out_valid, out_y
  );

  modport master (
    output in_valid, in_code, in_any, out_ready,
    input  in_ready, out_valid, out_y
  );

endinterface

// File: rtl/pd_skid_buf.sv
// Generic 2-entry valid/ready skid stage; upstream ready depends only on the skid register.
module pd_skid_buf #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);

  logic         r_main_v;
  logic [W-1:0] r_main_d;
  logic         r_skid_v;
  logic [W-1:0] r_skid_d;
  logic         w_in_fire;

  assign w_in_fire = i_valid & ~r_skid_v;
  assign o_ready   = ~r_skid_v;
  assign o_valid   = r_main_v;
  assign o_data    = r_main_d;

  // Main refills from skid first to keep FIFO order; skid only catches words during a stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_main_v <= 1'b0;
      r_main_d <= '0;
      r_skid_v <= 1'b0;
      r_skid_d <= '0;
    end else if (!r_main_v || i_ready) begin
      if (r_skid_v) begin
        r_main_d <= r_skid_d;
        r_main_v <= 1'b1;
        r_skid_v <= 1'b0;
      end else if (w_in_fire) begin
        r_main_d <= i_data;
        r_main_v <= 1'b1;
      end else begin
        r_main_v <= 1'b0;
      end
    end else if (w_in_fire) begin
      r_skid_d <= i_data;
      r_skid_v <= 1'b1;
    end
  end

endmodule

// File: rtl/pd24_decoder_pipe.sv
// Registered 2-to-4 one-hot decoder behind a 2-entry skid buffer.
// Optional per-line saturating hit counters enabled by PD24_HITCNT_EN.
module pd24_decoder_pipe
  import pd_pkg::*;
#(
  parameter int unsigned CODE_W = PD_CODE_W
`ifdef PD24_HITCNT_EN
  , parameter int unsigned CNT_W = PD_CNT_W
`endif
) (
  input  logic                     clk,
  input  logic                     rst,
  pd24_decoder_pipe_if.slave       bus
`ifdef PD24_HITCNT_EN
  , output logic [(1 << CODE_W)*CNT_W-1:0] hit_cnt
`endif
);

  localparam int unsigned OUT_W = 1 << CODE_W;

  logic [OUT_W-1:0] w_dec;

  // Decode ahead of storage so only one-hot (or all-zero) vectors are ever held.
  assign w_dec = bus.in_any ? (OUT_W'(1) << bus.in_code) : '0;

  pd_skid_buf #(
    .W(OUT_W)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_valid (bus.in_valid),
    .o_ready (bus.in_ready),
    .i_data  (w_dec),
    .o_valid (bus.out_valid),
    .i_ready (bus.out_ready),
    .o_data  (bus.out_y)
  );

`ifdef PD24_HITCNT_EN
  logic [CNT_W-1:0] r_cnt [OUT_W];
  logic             w_out_fire;

  assign w_out_fire = bus.out_valid & bus.out_ready;

  // Count delivered words per line, holding at the maximum value.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < OUT_W; i++) r_cnt[i] <= '0;
    end else if (w_out_fire) begin
      for (int i = 0; i < OUT_W; i++) begin
        if (bus.out_y[i] && (r_cnt[i] != {CNT_W{1'b1}})) r_cnt[i] <= r_cnt[i] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    hit_cnt = '0;
    for (int i = 0; i < OUT_W; i++) hit_cnt[i*CNT_W +: CNT_W] = r_cnt[i];
  end
`endif

endmodule

// File: tb/tb_pd24_decoder_pipe.sv
// Bench for pd24_decoder_pipe: directed cases plus random handshake traffic against a queue model.
module tb_pd24_decoder_pipe;
  import pd_pkg::*;

  localparam int unsigned CW   = 2;
  localparam int unsigned OW   = 4;
  localparam int unsigned CNTW = 2;
  localparam int          CMAX = (1 << CNTW) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pd24_decoder_pipe_if #(.CODE_W(CW)) bus ();

`ifdef PD24_HITCNT_EN
  logic [OW*CNTW-1:0] hit_cnt;
`endif

  pd24_decoder_pipe #(
    .CODE_W(CW)
`ifdef PD24_HITCNT_EN
    , .CNT_W(CNTW)
`endif
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef PD24_HITCNT_EN
    , .hit_cnt (hit_cnt)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [OW-1:0] q[$];
  int            exp_cnt[OW];
  logic [OW-1:0] hold_y;
  bit            hold_v;
  logic [2:0]    seen;
  int            n_out;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [OW-1:0] ref_dec(input int code, input bit any);
    return any ? OW'(1 << code) : '0;
  endfunction

  function automatic logic [31:0] model_cnt_vec();
    logic [31:0] v = '0;
    for (int i = 0; i < OW; i++) v[i*CNTW +: CNTW] = CNTW'(exp_cnt[i]);
    return v;
  endfunction

  // One clock of traffic: drive at negedge, score fires seen before the next posedge.
  task automatic cyc(input bit v, input int code, input bit any, input bit ordy);
    logic [OW-1:0] e;
    bus.in_valid  = v;
    bus.in_code   = CW'(code);
    bus.in_any    = any;
    bus.out_ready = ordy;
    #1;
    seen[q.size()] = 1'b1;
    check("in_ready", 32'(bus.in_ready), 32'(q.size() < 2));
    check("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
    if (hold_v) check("stall_stable", 32'(bus.out_y), 32'(hold_y));
    if (bus.out_valid && ordy) begin
      if (q.size() == 0) begin
        check("unexpected_out", 32'(bus.out_y), 32'hdead);
      end else begin
        e = q.pop_front();
        check("out_y", 32'(bus.out_y), 32'(e));
        n_out++;
        for (int i = 0; i < OW; i++)
          if (e[i] && exp_cnt[i] < CMAX) exp_cnt[i]++;
      end
    end
    if (v && bus.in_ready) q.push_back(ref_dec(code, any));
    hold_v = bus.out_valid && !ordy;
    hold_y = bus.out_y;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    hold_v = 1'b0;
    for (int i = 0; i < OW; i++) exp_cnt[i] = 0;
  endtask

  task automatic drain();
    for (int k = 0; k < 8 && q.size() > 0; k++) cyc(0, 0, 0, 1);
    check("drained", 32'(q.size()), 32'd0);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_code   = '0;
    bus.in_any    = 1'b0;
    bus.out_ready = 1'b0;
    seen  = '0;
    n_out = 0;
    @(negedge clk);
    do_reset();

    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Back-to-back stream, one cycle latency
    for (int c = 0; c < 4; c++) begin
      check("stream_in_ready", 32'(bus.in_ready), 32'd1);
      cyc(1, c, 1, 1);
      check("stream_latency_valid", 32'(bus.out_valid), 32'd1);
      check("stream_y", 32'(bus.out_y), 32'(ref_dec(c, 1)));
    end
    drain();

    // any=0 is a real transfer of all-zero
    cyc(1, 3, 0, 1);
    check("zero_word_valid", 32'(bus.out_valid), 32'd1);
    check("zero_word_y", 32'(bus.out_y), 32'd0);
    drain();
`ifdef PD24_HITCNT_EN
    check("zero_word_cnt", 32'(hit_cnt), 32'(model_cnt_vec()));
`endif

    // Stall fills both entries; third word refused
    cyc(1, 1, 1, 0);
    cyc(1, 2, 1, 0);
    check("full_in_ready", 32'(bus.in_ready), 32'd0);
    check("full_y", 32'(bus.out_y), 32'h2);
    cyc(1, 3, 1, 0);
    check("third_refused_depth", 32'(q.size()), 32'd2);
    check("full_hold_y", 32'(bus.out_y), 32'h2);
    cyc(0, 0, 0, 1);
    check("drain_second", 32'(bus.out_y), 32'h4);
    drain();

    // Random traffic
    for (int k = 0; k < 20000 && n_out < 1000; k++)
      cyc($urandom_range(0, 1), $urandom_range(0, 3), ($urandom_range(0, 3) != 0), $urandom_range(0, 1));
    check("random_words_out", 32'(n_out >= 1000), 32'd1);
    drain();
    check("states_seen", 32'(seen), 32'h7);
`ifdef PD24_HITCNT_EN
    check("random_cnt", 32'(hit_cnt), 32'(model_cnt_vec()));
`endif

    // Reset while full discards everything
    cyc(1, 1, 1, 0);
    cyc(1, 2, 1, 0);
    check("prerst_full", 32'(bus.in_ready), 32'd0);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    hold_v = 1'b0;
    for (int i = 0; i < OW; i++) exp_cnt[i] = 0;
    check("postrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("postrst_in_ready", 32'(bus.in_ready), 32'd1);
`ifdef PD24_HITCNT_EN
    check("postrst_cnt", 32'(hit_cnt), 32'd0);
`endif
    cyc(1, 3, 1, 1);
    check("postrst_y", 32'(bus.out_y), 32'h8);
    drain();

`ifdef PD24_HITCNT_EN
    // Saturation of line 0
    do_reset();
    for (int k = 0; k < 5; k++) cyc(1, 0, 1, 1);
    drain();
    check("sat_line0", 32'(hit_cnt[CNTW-1:0]), 32'(CMAX));
    check("sat_others", 32'(hit_cnt[OW*CNTW-1:CNTW]), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
